// File: rtl/prefetch_queue.sv
// Sequential-fetch prefetch queue: issues word fetches on a credit basis and buffers {pc, word} for the decoder.
// Optional build macro PREFETCH_BYPASS_EN forwards a response straight to the decoder when the queue is empty.
module prefetch_queue #(
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DEPTH      = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
   parameter int unsigned       STEP       = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     fetch_req,
   output logic [ADDR_W-1:0]        fetch_addr,
   input  logic                     mem_valid,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     flush,
   input  logic [ADDR_W-1:0]        flush_addr,
   output logic                     ins_valid,
   output logic [DATA_W-1:0]        ins,
   output logic [ADDR_W-1:0]        ins_pc,
   input  logic                     ins_ready,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] fpc;
   logic [CW-1:0]     cnt_q, cnt_n, outstanding, discard;
   logic [PW-1:0]     rd_ptr, wr_ptr, rd_n, pc_rd, pc_wr;
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [ADDR_W-1:0] pcf    [DEPTH];
   logic              ins_valid_q;
   logic [DATA_W-1:0] ins_q;
   logic [ADDR_W-1:0] ins_pc_q;
   logic [ADDR_W-1:0] head_pc;
   logic [CW:0]       credits;
   logic              keep, push, pop, byp_take, head_is_new;

   always_comb begin
      credits     = {1'b0, cnt_q} + {1'b0, outstanding};
      // Credits count in-flight requests too, so every response always has a slot.
      fetch_req   = !reset && !flush && (credits < (CW+1)'(DEPTH));
      fetch_addr  = fpc;
      head_pc     = pcf[pc_rd];
      keep        = mem_valid && (discard == '0) && !flush;
`ifdef PREFETCH_BYPASS_EN
      byp_take    = keep && (cnt_q == '0) && ins_ready;
`else
      byp_take    = 1'b0;
`endif
      push        = keep && !byp_take;
      pop         = ins_valid_q && ins_ready && !flush;
      rd_n        = pop ? rd_ptr + PW'(1) : rd_ptr;
      cnt_n       = cnt_q + CW'(push) - CW'(pop);
      head_is_new = push && (wr_ptr == rd_n);
   end

`ifdef PREFETCH_BYPASS_EN
   logic byp;
   assign byp       = keep && (cnt_q == '0);
   assign ins_valid = ins_valid_q || byp;
   assign ins       = byp ? mem_rdata : ins_q;
   assign ins_pc    = byp ? head_pc : ins_pc_q;
`else
   assign ins_valid = ins_valid_q;
   assign ins       = ins_q;
   assign ins_pc    = ins_pc_q;
`endif
   assign count = cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fpc         <= RESET_ADDR;
         cnt_q       <= '0;
         outstanding <= '0;
         discard     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         pc_rd       <= '0;
         pc_wr       <= '0;
         ins_valid_q <= 1'b0;
         ins_q       <= '0;
         ins_pc_q    <= '0;
      end else begin
         // The PC FIFO tracks every request, including ones later discarded.
         if (fetch_req) begin
            pcf[pc_wr] <= fpc;
            pc_wr      <= pc_wr + PW'(1);
         end
         if (mem_valid) pc_rd <= pc_rd + PW'(1);

         if (flush) begin
            fpc         <= flush_addr;
            cnt_q       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            ins_valid_q <= 1'b0;
            // Pending discards are a subset of outstanding, so repeated flushes never over-count.
            outstanding <= outstanding - CW'(mem_valid);
            discard     <= outstanding - CW'(mem_valid);
         end else begin
            if (fetch_req) fpc <= fpc + ADDR_W'(STEP);
            outstanding <= outstanding + CW'(fetch_req) - CW'(mem_valid);
            if (mem_valid && (discard != '0)) discard <= discard - CW'(1);
            if (push) begin
               data_q[wr_ptr] <= mem_rdata;
               pc_q[wr_ptr]   <= head_pc;
               wr_ptr         <= wr_ptr + PW'(1);
            end
            rd_ptr      <= rd_n;
            cnt_q       <= cnt_n;
            ins_valid_q <= (cnt_n != '0);
            if (cnt_n != '0) begin
               ins_q    <= head_is_new ? mem_rdata : data_q[rd_n];
               ins_pc_q <= head_is_new ? head_pc : pc_q[rd_n];
            end else if (byp_take) begin
               ins_q    <= mem_rdata;
               ins_pc_q <= head_pc;
            end
         end
      end
   end
endmodule
